alu_rs_scheduler: RTL and testbench
===================================

ALU_RS_SCHEDULER -- requirements
Module: alu_rs_scheduler

Interface
REQ-001 SHALL have parameter RS_SIZE, default 8, number of reservation entries (power of 2, 2..16).
REQ-002 SHALL have parameters OP_WIDTH 7, VAL_WIDTH 32, ID_WIDTH 4: op-type, operand and ROB-tag widths matching the ALU.
REQ-003 SHALL have ports: clk in 1, single clock; rst_in in 1, reset, asynchronous, active-low; rdy_in in 1, global stall when low.
REQ-004 SHALL have dispatch ports: dis_valid in 1; dis_type in OP_WIDTH; dis_val1/dis_val2 in VAL_WIDTH; dis_rdy1/dis_rdy2 in 1, operand valid; dis_q1/dis_q2 in ID_WIDTH, producer tag; dis_entry in ID_WIDTH, destination ROB tag; rs_full out 1.
REQ-005 SHALL have wakeup ports: alu_wb_valid in 1, alu_wb_entry in ID_WIDTH, alu_wb_val in VAL_WIDTH; cdb_valid in 1, cdb_entry in ID_WIDTH, cdb_val in VAL_WIDTH.
REQ-006 SHALL have flush in 1, discard all entries.
REQ-007 SHALL have issue outputs: execute out 1; type out OP_WIDTH; val1/val2 out VAL_WIDTH; entry out ID_WIDTH; all driven directly to the ALU.

Function
REQ-008 All state and outputs SHALL hold unchanged on any clk edge with rdy_in low; all inputs are ignored that cycle.
REQ-009 Each entry SHALL hold busy, type, val1, val2, rdy1, rdy2, q1, q2, dest tag; entry ready = busy & rdy1 & rdy2.
REQ-010 Dispatch: with rdy_in high, dis_valid high, rs_full low, SHALL write the lowest-index non-busy entry and set busy at the edge.
REQ-011 rs_full SHALL be combinational = (busy count == RS_SIZE) from registered state; dispatch while full is dropped silently; a same-cycle issue does not free space for that cycle's dispatch.
REQ-012 Wakeup: for each busy entry with rdyN low, a valid broadcast whose tag equals qN SHALL set rdyN and load valN at that edge; both ports are checked in parallel; if both match, the ALU port wins (values identical by construction).
REQ-013 Issue: at each edge with rdy_in high and flush low, if any entry is ready (registered state), SHALL select the lowest-index ready entry, register its fields onto type/val1/val2/entry, drive execute high for exactly one cycle, and clear its busy.
REQ-014 If no entry is ready, execute SHALL go low at the edge; type/val1/val2/entry hold their previous values.
REQ-015 Latency: an entry dispatched with both operands valid at edge t SHALL be issued no earlier than edge t+1; an operand woken at edge t makes its entry eligible from edge t+1.
REQ-016 At most one dispatch and one issue per cycle; they SHALL never target the same entry in one cycle.
REQ-017 flush with rdy_in high SHALL clear all busy and drive execute low at the edge, overriding dispatch, wakeup and issue that cycle.
REQ-018 Tag comparisons SHALL use the full ID_WIDTH; no tag value is reserved.

Reset
REQ-019 rst_in low SHALL asynchronously clear all busy, rdy1, rdy2 and drive execute 0, type 0, val1 0, val2 0, entry 0; rs_full reads 0.
REQ-020 Reset asserted mid-operation SHALL discard all entries immediately; first dispatch is accepted on the first edge after rst_in rises.

Configuration
REQ-021 Macro RS_DISPATCH_BYPASS_EN SHALL, when defined, let a dispatching operand with dis_rdyN low capture a same-cycle matching alu_wb/cdb broadcast (tag == dis_qN) and store rdyN=1 with the broadcast value.
REQ-022 Without RS_DISPATCH_BYPASS_EN, the dispatched operand SHALL store rdyN=0 and wait for a later broadcast; the producer must guarantee no tag is broadcast in its dispatch cycle.

Verification
REQ-023 Dispatch addi (dis_rdy1=dis_rdy2=1, val1=5, val2=7, entry=3) at edge 0 -> execute=1, val1=5, val2=7, entry=3 after edge 1, execute=0 after edge 2.
REQ-024 Fill 8 entries with dis_rdy1=0, q1=2 -> rs_full=1, 9th dispatch dropped; cdb_valid, cdb_entry=2, cdb_val=0x10 -> entries 0..7 issue on 8 consecutive edges in index order, each val1=0x10.
REQ-025 Entries 1 and 4 ready simultaneously, entry 0 waiting -> entry 1 issues first, entry 4 next edge.
REQ-026 rdy_in low for 3 cycles with a ready entry and dis_valid=1 -> no issue, no dispatch, outputs frozen; issue resumes on first edge with rdy_in high.
REQ-027 flush with 5 busy entries and dis_valid=1 same cycle -> execute=0, rs_full=0, no entry issues afterwards; rst_in pulsed low mid-issue -> execute=0 immediately, asynchronously.
REQ-028 With RS_DISPATCH_BYPASS_EN, dispatch dis_rdy2=0, dis_q2=6 while alu_wb_valid=1, alu_wb_entry=6, alu_wb_val=9 -> entry issues next edge with val2=9; without macro -> entry never issues until a later tag-6 broadcast.

Source files
------------

// File: rtl/alu_rs_scheduler.sv
// ALU reservation station: in-order-free dispatch into the lowest free slot, tag wakeup from two
// broadcast ports, issue of the lowest-index ready slot. Optional macro RS_DISPATCH_BYPASS_EN.
module alu_rs_scheduler #(
    parameter int RS_SIZE   = 8,
    parameter int OP_WIDTH  = 7,
    parameter int VAL_WIDTH = 32,
    parameter int ID_WIDTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 dis_valid,
    input  logic [OP_WIDTH-1:0]  dis_type,
    input  logic [VAL_WIDTH-1:0] dis_val1,
    input  logic [VAL_WIDTH-1:0] dis_val2,
    input  logic                 dis_rdy1,
    input  logic                 dis_rdy2,
    input  logic [ID_WIDTH-1:0]  dis_q1,
    input  logic [ID_WIDTH-1:0]  dis_q2,
    input  logic [ID_WIDTH-1:0]  dis_entry,
    output logic                 rs_full,
    input  logic                 alu_wb_valid,
    input  logic [ID_WIDTH-1:0]  alu_wb_entry,
    input  logic [VAL_WIDTH-1:0] alu_wb_val,
    input  logic                 cdb_valid,
    input  logic [ID_WIDTH-1:0]  cdb_entry,
    input  logic [VAL_WIDTH-1:0] cdb_val,
    input  logic                 flush,
    output logic                 execute,
    output logic [OP_WIDTH-1:0]  op_type,
    output logic [VAL_WIDTH-1:0] val1,
    output logic [VAL_WIDTH-1:0] val2,
    output logic [ID_WIDTH-1:0]  entry
);
    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    typedef struct packed {
        logic                 busy;
        logic [OP_WIDTH-1:0]  op;
        logic [VAL_WIDTH-1:0] val1;
        logic [VAL_WIDTH-1:0] val2;
        logic                 rdy1;
        logic                 rdy2;
        logic [ID_WIDTH-1:0]  q1;
        logic [ID_WIDTH-1:0]  q2;
        logic [ID_WIDTH-1:0]  dest;
    } rs_entry_t;

    rs_entry_t            rs [RS_SIZE];
    logic [RS_SIZE-1:0]   busy_vec;
    logic [RS_SIZE-1:0]   ready_vec;
    logic [IDX_W-1:0]     free_idx;
    logic [IDX_W-1:0]     issue_idx;
    logic                 have_issue;
    logic                 d_rdy1, d_rdy2;
    logic [VAL_WIDTH-1:0] d_val1, d_val2;

    // Scanning high-to-low leaves the lowest matching index in the result.
    always_comb begin
        busy_vec   = '0;
        ready_vec  = '0;
        free_idx   = '0;
        issue_idx  = '0;
        have_issue = 1'b0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            busy_vec[i]  = rs[i].busy;
            ready_vec[i] = rs[i].busy & rs[i].rdy1 & rs[i].rdy2;
            if (!rs[i].busy) free_idx = IDX_W'(i);
            if (ready_vec[i]) begin
                issue_idx  = IDX_W'(i);
                have_issue = 1'b1;
            end
        end
    end

    assign rs_full = &busy_vec;

    always_comb begin
        d_rdy1 = dis_rdy1;
        d_rdy2 = dis_rdy2;
        d_val1 = dis_val1;
        d_val2 = dis_val2;
`ifdef RS_DISPATCH_BYPASS_EN
        // Catch a producer broadcasting in the very cycle its consumer dispatches.
        if (!dis_rdy1) begin
            if (alu_wb_valid && alu_wb_entry == dis_q1) begin
                d_rdy1 = 1'b1;
                d_val1 = alu_wb_val;
            end else if (cdb_valid && cdb_entry == dis_q1) begin
                d_rdy1 = 1'b1;
                d_val1 = cdb_val;
            end
        end
        if (!dis_rdy2) begin
            if (alu_wb_valid && alu_wb_entry == dis_q2) begin
                d_rdy2 = 1'b1;
                d_val2 = alu_wb_val;
            end else if (cdb_valid && cdb_entry == dis_q2) begin
                d_rdy2 = 1'b1;
                d_val2 = cdb_val;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < RS_SIZE; i++) rs[i] <= '0;
            execute <= 1'b0;
            op_type <= '0;
            val1    <= '0;
            val2    <= '0;
            entry   <= '0;
        end else if (rdy_in) begin
            if (flush) begin
                for (int i = 0; i < RS_SIZE; i++) rs[i].busy <= 1'b0;
                execute <= 1'b0;
            end else begin
                // ALU port checked first so it wins when both ports carry the tag.
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (rs[i].busy && !rs[i].rdy1) begin
                        if (alu_wb_valid && alu_wb_entry == rs[i].q1) begin
                            rs[i].rdy1 <= 1'b1;
                            rs[i].val1 <= alu_wb_val;
                        end else if (cdb_valid && cdb_entry == rs[i].q1) begin
                            rs[i].rdy1 <= 1'b1;
                            rs[i].val1 <= cdb_val;
                        end
                    end
                    if (rs[i].busy && !rs[i].rdy2) begin
                        if (alu_wb_valid && alu_wb_entry == rs[i].q2) begin
                            rs[i].rdy2 <= 1'b1;
                            rs[i].val2 <= alu_wb_val;
                        end else if (cdb_valid && cdb_entry == rs[i].q2) begin
                            rs[i].rdy2 <= 1'b1;
                            rs[i].val2 <= cdb_val;
                        end
                    end
                end

                if (have_issue) begin
                    execute             <= 1'b1;
                    op_type             <= rs[issue_idx].op;
                    val1                <= rs[issue_idx].val1;
                    val2                <= rs[issue_idx].val2;
                    entry               <= rs[issue_idx].dest;
                    rs[issue_idx].busy  <= 1'b0;
                end else begin
                    execute <= 1'b0;
                end

                // free_idx is never busy and issue_idx always is, so they cannot collide.
                if (dis_valid && !rs_full) begin
                    rs[free_idx].busy <= 1'b1;
                    rs[free_idx].op   <= dis_type;
                    rs[free_idx].val1 <= d_val1;
                    rs[free_idx].val2 <= d_val2;
                    rs[free_idx].rdy1 <= d_rdy1;
                    rs[free_idx].rdy2 <= d_rdy2;
                    rs[free_idx].q1   <= dis_q1;
                    rs[free_idx].q2   <= dis_q2;
                    rs[free_idx].dest <= dis_entry;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Directed bench for alu_rs_scheduler: a table of single-op dispatch/issue vectors followed by
// hand-written sequences for fill/wakeup order, priority, stall, flush, reset and dispatch bypass.
module tb_alu_rs_scheduler;
    logic        clk = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        dis_valid = 1'b0;
    logic [6:0]  dis_type = '0;
    logic [31:0] dis_val1 = '0, dis_val2 = '0;
    logic        dis_rdy1 = 1'b0, dis_rdy2 = 1'b0;
    logic [3:0]  dis_q1 = '0, dis_q2 = '0, dis_entry = '0;
    logic        rs_full;
    logic        alu_wb_valid = 1'b0;
    logic [3:0]  alu_wb_entry = '0;
    logic [31:0] alu_wb_val = '0;
    logic        cdb_valid = 1'b0;
    logic [3:0]  cdb_entry = '0;
    logic [31:0] cdb_val = '0;
    logic        flush = 1'b0;
    logic        execute;
    logic [6:0]  op_type;
    logic [31:0] val1, val2;
    logic [3:0]  entry;

    int pass_cnt = 0;
    int total    = 0;

    alu_rs_scheduler dut (
        .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in),
        .dis_valid(dis_valid), .dis_type(dis_type), .dis_val1(dis_val1), .dis_val2(dis_val2),
        .dis_rdy1(dis_rdy1), .dis_rdy2(dis_rdy2), .dis_q1(dis_q1), .dis_q2(dis_q2),
        .dis_entry(dis_entry), .rs_full(rs_full),
        .alu_wb_valid(alu_wb_valid), .alu_wb_entry(alu_wb_entry), .alu_wb_val(alu_wb_val),
        .cdb_valid(cdb_valid), .cdb_entry(cdb_entry), .cdb_val(cdb_val),
        .flush(flush), .execute(execute), .op_type(op_type),
        .val1(val1), .val2(val2), .entry(entry)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  typ;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [3:0]  dest;
        logic [6:0]  exp_type;
        logic [31:0] exp_v1;
        logic [31:0] exp_v2;
        logic [3:0]  exp_entry;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dis(input logic [6:0] t, input logic [31:0] a, input logic [31:0] b,
                       input logic r1, input logic r2, input logic [3:0] q1,
                       input logic [3:0] q2, input logic [3:0] dest);
        dis_valid = 1'b1; dis_type = t; dis_val1 = a; dis_val2 = b;
        dis_rdy1 = r1; dis_rdy2 = r2; dis_q1 = q1; dis_q2 = q2; dis_entry = dest;
    endtask

    task automatic idle();
        dis_valid = 1'b0; alu_wb_valid = 1'b0; cdb_valid = 1'b0; flush = 1'b0; rdy_in = 1'b1;
    endtask

    initial begin
        vecs[0] = '{7'h13, 32'd5,         32'd7,         4'd3,  7'h13, 32'd5,         32'd7,         4'd3};
        vecs[1] = '{7'h33, 32'h0,         32'h0,         4'd0,  7'h33, 32'h0,         32'h0,         4'd0};
        vecs[2] = '{7'h7f, 32'hffff_ffff, 32'hffff_ffff, 4'd15, 7'h7f, 32'hffff_ffff, 32'hffff_ffff, 4'd15};
        vecs[3] = '{7'h01, 32'h8000_0000, 32'h0000_0001, 4'd8,  7'h01, 32'h8000_0000, 32'h0000_0001, 4'd8};
        vecs[4] = '{7'h2a, 32'hdead_beef, 32'h1234_5678, 4'd7,  7'h2a, 32'hdead_beef, 32'h1234_5678, 4'd7};

        // reset state
        tick(); tick();
        check("reset_execute", {31'b0, execute}, 32'd0);
        check("reset_full", {31'b0, rs_full}, 32'd0);
        check("reset_type", {25'b0, op_type}, 32'd0);
        check("reset_val1", val1, 32'd0);
        check("reset_val2", val2, 32'd0);
        check("reset_entry", {28'b0, entry}, 32'd0);
        rst_in = 1'b1;

        // table: each op dispatches ready, issues one edge later
        for (int k = 0; k < 5; k++) begin
            dis(vecs[k].typ, vecs[k].v1, vecs[k].v2, 1'b1, 1'b1, 4'd0, 4'd0, vecs[k].dest);
            tick();
            idle();
            check($sformatf("v%0d_no_early_issue", k), {31'b0, execute}, 32'd0);
            tick();
            check($sformatf("v%0d_execute", k), {31'b0, execute}, 32'd1);
            check($sformatf("v%0d_type", k), {25'b0, op_type}, {25'b0, vecs[k].exp_type});
            check($sformatf("v%0d_val1", k), val1, vecs[k].exp_v1);
            check($sformatf("v%0d_val2", k), val2, vecs[k].exp_v2);
            check($sformatf("v%0d_entry", k), {28'b0, entry}, {28'b0, vecs[k].exp_entry});
        end
        tick();
        check("exec_one_cycle", {31'b0, execute}, 32'd0);
        check("hold_entry_after_idle", {28'b0, entry}, 32'd7);

        // fill all slots waiting on tag 2, overflow dispatch dropped, then one CDB wakes all
        for (int i = 0; i < 8; i++) begin
            dis(7'h10, 32'h0, 32'(i), 1'b0, 1'b1, 4'd2, 4'd0, 4'(i));
            tick();
        end
        check("full_after_8", {31'b0, rs_full}, 32'd1);
        dis(7'h10, 32'h0, 32'h99, 1'b1, 1'b1, 4'd0, 4'd0, 4'd9);
        tick();
        check("full_drop_exec", {31'b0, execute}, 32'd0);
        check("full_still", {31'b0, rs_full}, 32'd1);
        idle();
        cdb_valid = 1'b1; cdb_entry = 4'd2; cdb_val = 32'h10;
        tick();
        idle();
        check("wake_edge_no_issue", {31'b0, execute}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("drain%0d_exec", i), {31'b0, execute}, 32'd1);
            check($sformatf("drain%0d_entry", i), {28'b0, entry}, 32'(i));
            check($sformatf("drain%0d_val1", i), val1, 32'h10);
            check($sformatf("drain%0d_val2", i), val2, 32'(i));
        end
        tick();
        check("dropped_never_issues", {31'b0, execute}, 32'd0);
        check("empty_not_full", {31'b0, rs_full}, 32'd0);

        // slots 1 and 4 wake together while slot 0 waits; ALU port wins over CDB
        dis(7'h20, 32'h0, 32'h0, 1'b0, 1'b1, 4'd5, 4'd0, 4'd10); tick();
        dis(7'h21, 32'h0, 32'h1, 1'b0, 1'b1, 4'd7, 4'd0, 4'd11); tick();
        dis(7'h22, 32'h0, 32'h2, 1'b0, 1'b1, 4'd5, 4'd0, 4'd12); tick();
        dis(7'h23, 32'h0, 32'h3, 1'b0, 1'b1, 4'd5, 4'd0, 4'd13); tick();
        dis(7'h24, 32'h0, 32'h4, 1'b0, 1'b1, 4'd7, 4'd0, 4'd14); tick();
        idle();
        alu_wb_valid = 1'b1; alu_wb_entry = 4'd7; alu_wb_val = 32'h77;
        cdb_valid = 1'b1; cdb_entry = 4'd7; cdb_val = 32'h99;
        tick();
        idle();
        tick();
        check("prio_first_entry", {28'b0, entry}, 32'd11);
        check("prio_alu_wins", val1, 32'h77);
        tick();
        check("prio_second_entry", {28'b0, entry}, 32'd14);
        check("prio_second_exec", {31'b0, execute}, 32'd1);
        tick();
        check("prio_waiters_hold", {31'b0, execute}, 32'd0);
        flush = 1'b1; tick(); idle();

        // stall: outputs and state frozen, flush and dispatch ignored while rdy_in low
        dis(7'h30, 32'hA, 32'hA, 1'b1, 1'b1, 4'd0, 4'd0, 4'd1); tick();
        dis(7'h31, 32'hB, 32'hB, 1'b1, 1'b1, 4'd0, 4'd0, 4'd2); tick();
        check("stall_pre_entry", {28'b0, entry}, 32'd1);
        dis(7'h32, 32'hC, 32'hC, 1'b1, 1'b1, 4'd0, 4'd0, 4'd3);
        rdy_in = 1'b0; flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stall%0d_exec", i), {31'b0, execute}, 32'd1);
            check($sformatf("stall%0d_entry", i), {28'b0, entry}, 32'd1);
        end
        idle();
        tick();
        check("resume_entry", {28'b0, entry}, 32'd2);
        check("resume_exec", {31'b0, execute}, 32'd1);
        tick();
        check("stall_dispatch_dropped", {31'b0, execute}, 32'd0);

        // flush with 5 busy (one ready) and a dispatch in the same cycle
        for (int i = 0; i < 4; i++) begin
            dis(7'h40, 32'h0, 32'h0, 1'b0, 1'b1, 4'd3, 4'd0, 4'(i)); tick();
        end
        dis(7'h41, 32'h1, 32'h1, 1'b1, 1'b1, 4'd0, 4'd0, 4'd4);
        tick();
        dis(7'h42, 32'h2, 32'h2, 1'b1, 1'b1, 4'd0, 4'd0, 4'd5);
        flush = 1'b1; cdb_valid = 1'b1; cdb_entry = 4'd3; cdb_val = 32'h3;
        tick();
        idle();
        check("flush_exec", {31'b0, execute}, 32'd0);
        check("flush_not_full", {31'b0, rs_full}, 32'd0);
        cdb_valid = 1'b1; cdb_entry = 4'd3; cdb_val = 32'h3;
        tick(); idle(); tick();
        check("flush_no_issue", {31'b0, execute}, 32'd0);

        // asynchronous reset in the middle of issuing
        dis(7'h50, 32'h5, 32'h5, 1'b1, 1'b1, 4'd0, 4'd0, 4'd6); tick();
        dis(7'h51, 32'h6, 32'h6, 1'b1, 1'b1, 4'd0, 4'd0, 4'd7); tick();
        idle();
        check("pre_reset_exec", {31'b0, execute}, 32'd1);
        rst_in = 1'b0;
        #1;
        check("async_reset_exec", {31'b0, execute}, 32'd0);
        check("async_reset_val1", val1, 32'd0);
        check("async_reset_entry", {28'b0, entry}, 32'd0);
        #1;
        rst_in = 1'b1;
        dis(7'h52, 32'h8, 32'h8, 1'b1, 1'b1, 4'd0, 4'd0, 4'd9);
        tick();
        idle();
        check("post_reset_discard", {31'b0, execute}, 32'd0);
        tick();
        check("post_reset_first_dis", {28'b0, entry}, 32'd9);
        check("post_reset_exec", {31'b0, execute}, 32'd1);
        tick();

        // same-cycle broadcast during dispatch
        dis(7'h60, 32'h1, 32'h0, 1'b1, 1'b0, 4'd0, 4'd6, 4'd5);
        alu_wb_valid = 1'b1; alu_wb_entry = 4'd6; alu_wb_val = 32'd9;
        tick();
        idle();
        tick();
`ifdef RS_DISPATCH_BYPASS_EN
        check("bypass_exec", {31'b0, execute}, 32'd1);
        check("bypass_val2", val2, 32'd9);
        check("bypass_entry", {28'b0, entry}, 32'd5);
`else
        check("nobypass_wait", {31'b0, execute}, 32'd0);
        tick();
        check("nobypass_still_wait", {31'b0, execute}, 32'd0);
        cdb_valid = 1'b1; cdb_entry = 4'd6; cdb_val = 32'd9;
        tick();
        idle();
        tick();
        check("nobypass_exec", {31'b0, execute}, 32'd1);
        check("nobypass_val2", val2, 32'd9);
        check("nobypass_entry", {28'b0, entry}, 32'd5);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
